// File: rtl/mux_rr_reg_rs.sv
// CH-way (N+1)-bit channel mux with a single registered output stage.
// Selects by explicit index (mode 0) or round-robin arbitration (mode 1).
module mux_rr_reg_rs #(
    parameter int N    = 2,
    parameter int CH   = 4,
    parameter int SELW = $clog2(CH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CH*(N+1)-1:0] in_data,
    input  logic [CH-1:0]       in_valid,
    output logic [CH-1:0]       in_ready,
    input  logic                mode,
    input  logic [SELW-1:0]     sel,
    output logic [N:0]          out_data,
    output logic [SELW-1:0]     out_ch,
    output logic                out_valid,
    input  logic                out_ready
);

    // Handshake: a word moves on any side exactly when valid && ready are both
    // high at a rising edge; ready never depends on the sender's data, and the
    // only combinational path from out_ready leads to in_ready.

    logic            can_accept;
    logic            gnt_found;
    logic            grant;
    logic [SELW-1:0] gnt;
    logic [SELW-1:0] rr_ptr;
    logic [SELW:0]   scan_idx;
    logic [N:0]      gnt_data;

    assign can_accept = !out_valid || out_ready;

    always_comb begin
        gnt_found = 1'b0;
        gnt       = '0;
        scan_idx  = '0;
        if (mode == 1'b0) begin
            // An index outside 0..CH-1 matches no channel, so it never grants.
            for (int i = 0; i < CH; i++) begin
                if (sel == SELW'(i) && in_valid[i]) begin
                    gnt_found = 1'b1;
                    gnt       = SELW'(i);
                end
            end
        end else begin
            // Scan offsets from farthest to nearest so the nearest requester wins.
            for (int k = CH - 1; k >= 0; k--) begin
                scan_idx = {1'b0, rr_ptr} + (SELW+1)'(k);
                if (scan_idx >= (SELW+1)'(CH)) begin
                    scan_idx = scan_idx - (SELW+1)'(CH);
                end
                for (int i = 0; i < CH; i++) begin
                    if (scan_idx == (SELW+1)'(i) && in_valid[i]) begin
                        gnt_found = 1'b1;
                        gnt       = SELW'(i);
                    end
                end
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < CH; i++) begin
            if (gnt == SELW'(i)) begin
                gnt_data = in_data[i*(N+1) +: (N+1)];
            end
        end
    end

    assign grant = gnt_found && can_accept && rst_n;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < CH; i++) begin
            in_ready[i] = grant && (gnt == SELW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= '0;
        end else if (grant) begin
            out_valid <= 1'b1;
            out_data  <= gnt_data;
            out_ch    <= gnt;
            if (mode) begin
                rr_ptr <= (gnt == SELW'(CH - 1)) ? '0 : gnt + SELW'(1);
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_rr_reg_rs.sv
// Bench for mux_rr_reg_rs: directed scenarios plus random traffic checked
// against an arithmetic reference model of grant, output register and pointer.
module tb_mux_rr_reg_rs;

    localparam int CH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic [2:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready;

    logic [8:0]  in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic        mode3;
    logic [1:0]  sel3;
    logic [2:0]  out_data3;
    logic [1:0]  out_ch3;
    logic        out_valid3;
    logic        out_ready3;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int         m_ptr;
    logic       m_ov;
    logic [2:0] m_data;
    int         m_ch;

    always #5 clk = ~clk;

    mux_rr_reg_rs #(.N(2), .CH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
    );

    mux_rr_reg_rs #(.N(2), .CH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .mode(mode3), .sel(sel3), .out_data(out_data3),
        .out_ch(out_ch3), .out_valid(out_valid3), .out_ready(out_ready3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_ov   = 1'b0;
        m_data = '0;
        m_ch   = 0;
    endtask

    // Expected grant from current inputs and model state; -1 means none.
    function automatic int exp_gnt();
        int c;
        if (m_ov && !out_ready) return -1;
        if (!mode) return in_valid[sel] ? int'(sel) : -1;
        for (int k = 0; k < CH; k++) begin
            c = (m_ptr + k) % CH;
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic cycle();
        int         g;
        logic [3:0] exp_rdy;
        #1;
        g = exp_gnt();
        exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
        if (g >= 0) begin
            m_ov   = 1'b1;
            m_data = in_data[g*3 +: 3];
            m_ch   = g;
            if (mode) m_ptr = (g + 1) % CH;
        end else if (out_ready && m_ov) begin
            m_ov = 1'b0;
        end
        check("out_valid", 32'(out_valid), 32'(m_ov));
        check("out_data", 32'(out_data), 32'(m_data));
        check("out_ch", 32'(out_ch), 32'(m_ch));
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        in_data = '0; in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;
        in_data3 = '0; in_valid3 = '0; mode3 = 1'b0; sel3 = '0; out_ready3 = 1'b0;
        model_reset();

        // reset held with inputs toggling
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_data = 12'($urandom); in_valid = 4'($urandom);
            mode = 1'($urandom); sel = 2'($urandom); out_ready = 1'($urandom);
            #1;
            check("rst_valid", 32'(out_valid), 32'd0);
            check("rst_data", 32'(out_data), 32'd0);
            check("rst_ch", 32'(out_ch), 32'd0);
            check("rst_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid = '0; out_ready = 1'b1; mode = 1'b0; sel = '0;
        rst_n = 1'b1;
        cycle();
        cycle();

        // explicit select
        in_data = {3'b111, 3'b100, 3'b010, 3'b001};
        in_valid = 4'b1111; sel = 2'd2; mode = 1'b0; out_ready = 1'b1;
        #1 check("m0_rdy_sel2", 32'(in_ready), 32'b0100);
        cycle();
        check("m0_data_sel2", 32'(out_data), 32'b100);
        sel = 2'd3;
        cycle();
        check("m0_data_sel3", 32'(out_data), 32'b111);
        check("m0_ch_sel3", 32'(out_ch), 32'd3);

        // round-robin fairness
        mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("rr_all", 32'(out_ch), 32'(i % 4));
        end
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("rr_1010", 32'(out_ch), (i % 2 == 0) ? 32'd1 : 32'd3);
        end

        // backpressure: one transfer, stall five cycles, then reload
        in_valid = 4'b1111;
        cycle();
        check("bp_first", 32'(out_ch), 32'd0);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_data = 12'($urandom);
            cycle();
            check("bp_hold_ch", 32'(out_ch), 32'd0);
            check("bp_hold_v", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        cycle();
        check("bp_reload", 32'(out_ch), 32'd1);

        // pointer survives mode-0 transfers (pointer is now 2)
        mode = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sel = 2'($urandom);
            cycle();
        end
        mode = 1'b1;
        cycle();
        check("rr_resume", 32'(out_ch), 32'd2);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            in_data = 12'($urandom); in_valid = 4'($urandom);
            mode = 1'($urandom); sel = 2'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        // async reset while stalled with a held word
        in_valid = 4'b1111; mode = 1'b1; out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        cycle();
        check("ar_pre_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(out_valid), 32'd0);
        check("ar_data", 32'(out_data), 32'd0);
        check("ar_ready", 32'(in_ready), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        cycle();
        check("ar_first_rr", 32'(out_ch), 32'd0);

        // CH=3: out-of-range select never grants, in-range select still works
        in_data3 = {3'b110, 3'b101, 3'b011};
        in_valid3 = 3'b111; mode3 = 1'b0; sel3 = 2'd3; out_ready3 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("ch3_rdy", 32'(in_ready3), 32'd0);
            check("ch3_valid", 32'(out_valid3), 32'd0);
        end
        sel3 = 2'd2;
        #1 check("ch3_rdy2", 32'(in_ready3), 32'b100);
        @(posedge clk);
        #1;
        check("ch3_data2", 32'(out_data3), 32'b110);
        check("ch3_ch2", 32'(out_ch3), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
